// File: rtl/arbitro_banco_registradores.sv
// Round-robin arbiter and sequencer in front of a 16-entry register bank.
// It also runs a command-driven sweep that writes zero to every register.
module arbitro_banco_registradores #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  Clock_in,
    input  logic                  Signal_reset,
    input  logic                  Req_A,
    input  logic                  Req_B,
    input  logic                  Wr_A,
    input  logic                  Wr_B,
    input  logic [ADDR_WIDTH-1:0] Rd_addr1_A,
    input  logic [ADDR_WIDTH-1:0] Rd_addr1_B,
    input  logic [ADDR_WIDTH-1:0] Rd_addr2_A,
    input  logic [ADDR_WIDTH-1:0] Rd_addr2_B,
    input  logic [ADDR_WIDTH-1:0] Wr_addr_A,
    input  logic [ADDR_WIDTH-1:0] Wr_addr_B,
    input  logic [DATA_WIDTH-1:0] Wr_data_A,
    input  logic [DATA_WIDTH-1:0] Wr_data_B,
    output logic                  Gnt_A,
    output logic                  Gnt_B,
    output logic                  Rd_valid_A,
    output logic                  Rd_valid_B,
    output logic [DATA_WIDTH-1:0] Rd_data1_A,
    output logic [DATA_WIDTH-1:0] Rd_data1_B,
    output logic [DATA_WIDTH-1:0] Rd_data2_A,
    output logic [DATA_WIDTH-1:0] Rd_data2_B,
    input  logic                  Clear_req,
    output logic                  Busy,
    output logic                  Clear_done,
    output logic [ADDR_WIDTH-1:0] Read_1,
    output logic [ADDR_WIDTH-1:0] Read_2,
    output logic [ADDR_WIDTH-1:0] Address_to_write,
    output logic [DATA_WIDTH-1:0] Data_to_write,
    output logic                  Signal_write,
    output logic                  Signal_read,
    input  logic [DATA_WIDTH-1:0] Out_1,
    input  logic [DATA_WIDTH-1:0] Out_2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic {
        ST_RUN,
        ST_CLEAR
    } state_t;

    state_t                  state_q, state_d;
    logic                    prio_q, prio_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    clear_done_q, clear_done_d;
    logic                    gnt_a, gnt_b;

    logic                    win_wr;
    logic [ADDR_WIDTH-1:0]   win_ra1, win_ra2, win_wa;
    logic [DATA_WIDTH-1:0]   win_wd;

    logic                    vld_p0, vld_p1;
    logic                    tag_p0, tag_p1;

    always_ff @(posedge Clock_in or negedge Signal_reset) begin
        if (!Signal_reset) begin
            state_q      <= ST_RUN;
            prio_q       <= 1'b0;
            cnt_q        <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            cnt_q        <= cnt_d;
            clear_done_q <= clear_done_d;
        end
    end

    // A clear command in RUN wins over any request pending in the same cycle.
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        cnt_d        = cnt_q;
        clear_done_d = 1'b0;
        gnt_a        = 1'b0;
        gnt_b        = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (Clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    if (Req_A && (!Req_B || !prio_q)) begin
                        gnt_a = 1'b1;
                    end else if (Req_B) begin
                        gnt_b = 1'b1;
                    end
                    if (gnt_a) begin
                        prio_d = 1'b1;
                    end else if (gnt_b) begin
                        prio_d = 1'b0;
                    end
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d      = ST_RUN;
                    clear_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        if (gnt_b) begin
            win_wr  = Wr_B;
            win_ra1 = Rd_addr1_B;
            win_ra2 = Rd_addr2_B;
            win_wa  = Wr_addr_B;
            win_wd  = Wr_data_B;
        end else begin
            win_wr  = Wr_A;
            win_ra1 = Rd_addr1_A;
            win_ra2 = Rd_addr2_A;
            win_wa  = Wr_addr_A;
            win_wd  = Wr_data_A;
        end
    end

    // Stage p0: bank control registers and read tag, one cycle after grant.
    always_ff @(posedge Clock_in or negedge Signal_reset) begin
        if (!Signal_reset) begin
            Signal_write     <= 1'b0;
            Signal_read      <= 1'b0;
            Read_1           <= '0;
            Read_2           <= '0;
            Address_to_write <= '0;
            Data_to_write    <= '0;
            vld_p0           <= 1'b0;
            tag_p0           <= 1'b0;
        end else begin
            Signal_write <= 1'b0;
            Signal_read  <= 1'b0;
            vld_p0       <= 1'b0;
            tag_p0       <= gnt_b;
            if (state_q == ST_CLEAR) begin
                Signal_write     <= 1'b1;
                Address_to_write <= cnt_q;
                Data_to_write    <= '0;
            end else if (gnt_a || gnt_b) begin
                if (win_wr) begin
                    Signal_write     <= 1'b1;
                    Address_to_write <= win_wa;
                    Data_to_write    <= win_wd;
                end else begin
                    Signal_read <= 1'b1;
                    Read_1      <= win_ra1;
                    Read_2      <= win_ra2;
                    vld_p0      <= 1'b1;
                end
            end
        end
    end

    // Stage p1: tag aligned with the bank's registered read data.
    always_ff @(posedge Clock_in or negedge Signal_reset) begin
        if (!Signal_reset) begin
            vld_p1 <= 1'b0;
            tag_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            tag_p1 <= tag_p0;
        end
    end

    assign Gnt_A      = gnt_a & Signal_reset;
    assign Gnt_B      = gnt_b & Signal_reset;
    assign Busy       = (state_q == ST_CLEAR);
    assign Clear_done = clear_done_q;

    assign Rd_valid_A = vld_p1 & ~tag_p1;
    assign Rd_valid_B = vld_p1 & tag_p1;
    assign Rd_data1_A = Rd_valid_A ? Out_1 : '0;
    assign Rd_data2_A = Rd_valid_A ? Out_2 : '0;
    assign Rd_data1_B = Rd_valid_B ? Out_1 : '0;
    assign Rd_data2_B = Rd_valid_B ? Out_2 : '0;

endmodule

// File: doc/arbitro_banco_registradores.md
# arbitro_banco_registradores

Two-requester arbiter and sequencer for the 16 × 32-bit register bank (`banco_de_registradores`, two read ports, one write port).
- Grants requesters A and B one bank transaction per cycle, round-robin under contention.
- Drives the bank's registered control inputs and steers the bank's read data back to the granted requester.
- Also runs a 16-cycle clear sweep that writes zero to every register on command.

## Interface
Parameters:
- DATA_WIDTH, 32, bank word width
- ADDR_WIDTH, 4, register address width; NUM_REGS = 2^ADDR_WIDTH = 16

Ports (x ∈ {A, B}, one line per A/B pair):
- Clock_in  in  1  single clock; all state updates on rising edge
- Signal_reset  in  1  asynchronous, active-low reset
- Req_A, Req_B  in  1  transaction request; held until granted
- Wr_A, Wr_B  in  1  1 = write, 0 = read; valid while Req_x high
- Rd_addr1_A, Rd_addr1_B  in  ADDR_WIDTH  read address, port 1
- Rd_addr2_A, Rd_addr2_B  in  ADDR_WIDTH  read address, port 2
- Wr_addr_A, Wr_addr_B  in  ADDR_WIDTH  write address
- Wr_data_A, Wr_data_B  in  DATA_WIDTH  write data
- Gnt_A, Gnt_B  out  1  combinational grant; the request is accepted at the edge ending the cycle
- Rd_valid_A, Rd_valid_B  out  1  read data valid, one-cycle pulse
- Rd_data1_A, Rd_data1_B  out  DATA_WIDTH  Out_1 steered to requester; 0 when Rd_valid_x is low
- Rd_data2_A, Rd_data2_B  out  DATA_WIDTH  Out_2 steered to requester; 0 when Rd_valid_x is low
- Clear_req  in  1  start clear sweep (level sampled at the edge)
- Busy  out  1  high during the clear sweep
- Clear_done  out  1  one-cycle pulse after the last clear write
- Read_1, Read_2, Address_to_write  out  ADDR_WIDTH  registered, to bank
- Data_to_write  out  DATA_WIDTH  registered, to bank
- Signal_write, Signal_read  out  1  registered, to bank
- Out_1, Out_2  in  DATA_WIDTH  bank read data

## Operation
States: IDLE/RUN (normal arbitration) and CLEAR. Priority pointer `prio` (0 = A, 1 = B).

Arbitration in RUN:
- Only Req_A high → Gnt_A; `prio` ← B.
- Only Req_B high → Gnt_B; `prio` ← A.
- Both high → grant the side named by `prio`; `prio` flips.
- Gnt_A and Gnt_B are never high together.
- Neither request → no grant; bank controls register Signal_write = Signal_read = 0, and addresses/data hold their previous values.

Granted write:
- Next cycle: Signal_write = 1, Signal_read = 0, Address_to_write / Data_to_write from the winner.

Granted read:
- Next cycle: Signal_read = 1, Signal_write = 0, Read_1 / Read_2 from the winner.
- A 1-bit tag records the winner. Two cycles after grant, Rd_valid_x pulses with Rd_data1_x = Out_1 and Rd_data2_x = Out_2.

Clear sweep:
- Clear_req = 1 at an edge in RUN → state CLEAR. Clear has priority over requests in that cycle, so no grant is given.
- In CLEAR: 4-bit counter 0..15. Each cycle registers Signal_write = 1, Address_to_write = counter, Data_to_write = 0.
- After the write for address 15 is issued → Clear_done pulses for one cycle, state returns to RUN, `prio` is unchanged.
- Busy = 1 in every CLEAR cycle. Gnt_x = 0 throughout; pending requests wait.
- Clear_req during CLEAR is ignored (no restart).
- Reads already in flight when the clear starts still return their Rd_valid pulse.

Reset (Signal_reset = 0, asynchronous):
- State → RUN, `prio` → A, counter → 0.
- All bank control outputs → 0.
- Gnt_x, Rd_valid_x, Rd_data*_x, Busy, Clear_done → 0. In-flight reads are discarded.
- Reset mid-sweep aborts the sweep with no Clear_done.

## Timing
- Grant to bank control: 1 cycle. Grant to bank action: the edge ending grant+1.
- Read latency from grant to Rd_valid: 2 cycles.
- Throughput: 1 transaction per cycle, back-to-back across requesters.
- A requester must drop or change Req_x at the edge where Gnt_x was high; a still-high Req_x is a new request.
- Write then read of the same register: a read granted ≥1 cycle after the write grant returns the new value. The bank returns the old value for a simultaneous write and read.
- Clear sweep: 16 write cycles. Clear_done falls in the cycle after the address-15 write is issued, and RUN grants resume that same cycle.

## Test plan
- Reset: Signal_reset = 0 for 2 cycles → every output 0, Busy = 0; release, no requests → Signal_write = Signal_read = 0.
- Single write then read: A writes 0x00000001 to r0; next cycle A reads r0 and r1 → Rd_valid_A two cycles after the read grant with Rd_data1_A = 1, Rd_data2_A = 0; Rd_valid_B never pulses.
- Contention: Req_A = Req_B = 1 for 4 consecutive new requests → grants A, B, A, B; from reset, B-only then both → B, then A.
- Routing: A reads r0 (= 1) and B reads r7 (= 7) back-to-back → each requester gets only its own data, in grant order, on consecutive cycles.
- Clear: preload r3 = 0xDEADBEEF, assert Clear_req with Req_A high → Busy for 16 cycles, writes to addresses 0..15 with data 0, Gnt_A = 0 throughout, Clear_done pulse, then Gnt_A; a subsequent read of r3 returns 0.
- Reset mid-clear: assert Signal_reset at counter = 5 → Busy = 0 immediately, no Clear_done, `prio` = A.
